// File: rtl/core_ctrl.sv
// core_ctrl: command/sample sequencer for the single-neuron MAC core.
// Streams samples into the datapath, then returns y or pulses done.
module core_ctrl #(
  parameter int N_MAX   = 100,
  parameter int DW      = 16,
  parameter int IW      = 7,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_bwd,
  input  logic [IW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_e,
  input  logic          x_vld,
  output logic          x_rdy,
  input  logic [DW-1:0] x,
  output logic [IW-1:0] idx,
  output logic          fwd,
  output logic          bwd,
  output logic          clr,
  output logic [DW-1:0] dx,
  output logic [DW-1:0] de,
  input  logic [DW-1:0] y_in,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [DW-1:0] res_y,
  output logic          done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  // one spare bit so len/cnt can hold N_MAX itself
  localparam int LW  = IW + 1;
  localparam int DCW = $clog2(MAC_LAT + 2);
  localparam logic [LW-1:0]  LMAX  = LW'(N_MAX);
  localparam logic [DCW-1:0] DLAST = DCW'(MAC_LAT);

  logic [1:0]     state;
  logic           mode;
  logic [LW-1:0]  len;
  logic [LW-1:0]  cnt;
  logic [LW-1:0]  cnt_nx;
  logic [LW-1:0]  clen;
  logic [DCW-1:0] dcnt;

  assign cmd_rdy = (state == S_IDLE);
  assign x_rdy   = (state == S_STREAM);
  assign cnt_nx  = cnt + LW'(1);
  assign clen    = ({1'b0, cmd_len} > LMAX) ?
                   LMAX : {1'b0, cmd_len};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mode    <= 1'b0;
      len     <= '0;
      cnt     <= '0;
      dcnt    <= '0;
      idx     <= '0;
      fwd     <= 1'b0;
      bwd     <= 1'b0;
      clr     <= 1'b0;
      dx      <= '0;
      de      <= '0;
      res_vld <= 1'b0;
      res_y   <= '0;
      done    <= 1'b0;
    end else begin
      fwd  <= 1'b0;
      bwd  <= 1'b0;
      clr  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            mode  <= cmd_bwd;
            de    <= cmd_e;
            len   <= clen;
            cnt   <= '0;
            dcnt  <= '0;
            clr   <= !cmd_bwd;
            state <= (clen == '0) ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (x_vld) begin
            dx  <= x;
            idx <= cnt[IW-1:0];
            fwd <= !mode;
            bwd <= mode;
            cnt <= cnt_nx;
            if (cnt_nx == len)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // last drain cycle: the final strobe has reached y_in
          if (dcnt == DLAST) begin
            if (mode) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              res_y   <= y_in;
              res_vld <= 1'b1;
              state   <= S_RESULT;
            end
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        S_RESULT: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: randomized and directed bench for core_ctrl.
// A toy MAC datapath supplies y_in; a transaction model predicts results.
module tb_core_ctrl;

  localparam int N_MAX   = 100;
  localparam int DW      = 16;
  localparam int IW      = 7;
  localparam int MAC_LAT = 1;

  logic          clk = 0;
  logic          rst;
  logic          cmd_vld, cmd_rdy, cmd_bwd;
  logic [IW-1:0] cmd_len;
  logic [DW-1:0] cmd_e;
  logic          x_vld, x_rdy;
  logic [DW-1:0] x;
  logic [IW-1:0] idx;
  logic          fwd, bwd, clr;
  logic [DW-1:0] dx, de, y_in;
  logic          res_vld, res_rdy;
  logic [DW-1:0] res_y;
  logic          done;

  core_ctrl #(.N_MAX(N_MAX), .DW(DW), .IW(IW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_bwd(cmd_bwd),
    .cmd_len(cmd_len), .cmd_e(cmd_e),
    .x_vld(x_vld), .x_rdy(x_rdy), .x(x),
    .idx(idx), .fwd(fwd), .bwd(bwd), .clr(clr),
    .dx(dx), .de(de), .y_in(y_in),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_y(res_y),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // toy datapath: one-cycle accumulator, y = sum w*x
  logic [DW-1:0] wmem [0:N_MAX-1];
  logic [DW-1:0] xs [0:127];
  logic [DW-1:0] acc;

  always @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (fwd) acc <= acc + wmem[idx] * dx;
  assign y_in = acc;

  typedef struct {
    int c;
    int i;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic b;
  } stb_t;

  stb_t stq[$];
  int clrq[$], doneq[$], accq[$], xaq[$], resq[$];
  logic [DW-1:0] ry0;
  bit ryflip;

  always @(negedge clk) if (rst) begin
    if (fwd || bwd) stq.push_back('{cyc, int'(idx), dx, de, bwd});
    if (clr) clrq.push_back(cyc);
    if (done) doneq.push_back(cyc);
    if (cmd_vld && cmd_rdy) accq.push_back(cyc);
    if (x_vld && x_rdy) xaq.push_back(cyc);
    if (res_vld) begin
      if (resq.size() == 0) ry0 = res_y;
      else if (res_y !== ry0) ryflip = 1;
      resq.push_back(cyc);
    end
  end

  task automatic wipe();
    stq.delete(); clrq.delete(); doneq.delete();
    accq.delete(); xaq.delete(); resq.delete();
    ryflip = 0; ry0 = '0;
  endtask

  function automatic int clampl(input int len);
    return len > N_MAX ? N_MAX : len;
  endfunction

  // reference: truncated dot product of the accepted samples
  function automatic logic [DW-1:0] model_y(input int len);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < clampl(len); k++)
      s = s + DW'(wmem[k] * xs[k]);
    return s;
  endfunction

  function automatic int t0();
    return accq.size() > 0 ? accq[0] : -1000;
  endfunction

  // stall: 0 none, 1 toggle 1/0, 2 random; rdly: res_rdy delay
  task automatic run(input logic b, input int len,
                     input logic [DW-1:0] e, input int stall,
                     input int rdly, output int tres);
    int k, n, elen;
    elen = clampl(len);
    wipe();
    res_rdy = (rdly == 0);
    cmd_vld = 1; cmd_bwd = b; cmd_len = IW'(len); cmd_e = e;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_rdy && n < 50);
    @(posedge clk); #1;
    cmd_vld = 0;
    k = 0; n = 0;
    while (k < elen && n < 2000) begin
      x_vld = (stall == 0) ? 1'b1 :
              (stall == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      x = x_vld ? xs[k] : DW'($urandom);
      @(negedge clk);
      if (x_vld && x_rdy) k++;
      @(posedge clk); #1;
      n++;
    end
    x_vld = 0;
    tres = -1; n = 0;
    while (tres < 0 && n < 400) begin
      @(negedge clk); n++;
      if (res_vld || done) tres = cyc;
    end
    if (tres < 0) begin
      n_chk++; n_fail++;
      $display("FAIL run_timeout: no res_vld/done, len=%0d bwd=%0b", len, b);
    end else if (!b) begin
      for (int i = 0; i < rdly; i++) begin @(posedge clk); #1; end
      res_rdy = 1;
    end
    @(posedge clk); #1;
    res_rdy = 0;
  endtask

  task automatic test_reset();
    cmd_vld = 0; cmd_bwd = 0; cmd_len = 0; cmd_e = 0;
    x_vld = 0; x = 0; res_rdy = 0;
    rst = 0;
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if ({cmd_rdy, x_rdy, fwd, bwd, clr, res_vld, done} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL por_ctrl: got %b want 1000000",
               {cmd_rdy, x_rdy, fwd, bwd, clr, res_vld, done});
    end
    n_chk++;
    if ({idx, dx, de, res_y} !== '0) begin
      n_fail++;
      $display("FAIL por_data: idx=%0d dx=%h de=%h res_y=%h want 0",
               idx, dx, de, res_y);
    end
    rst = 1;
    for (int k = 0; k < N_MAX; k++) wmem[k] = 16'd1;
    @(posedge clk); #1;
    cmd_vld = 1; cmd_bwd = 0; cmd_len = 7'd10; cmd_e = 16'h1234;
    @(posedge clk); #1;
    cmd_vld = 0; x_vld = 1; x = 16'h00a5;
    repeat (3) @(posedge clk); #1;
    n_chk++;
    if (fwd !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_fwd: got %b want 1", fwd);
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if ({cmd_rdy, x_rdy, fwd, bwd, clr, res_vld, done, idx, dx, de, res_y}
        !== {7'b1000000, 55'd0}) begin
      n_fail++;
      $display("FAIL async_reset: ctrl=%b idx=%0d dx=%h de=%h res_y=%h",
               {cmd_rdy, x_rdy, fwd, bwd, clr, res_vld, done},
               idx, dx, de, res_y);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({cmd_rdy, x_rdy, fwd, idx, de} !== {3'b100, 23'd0}) begin
      n_fail++;
      $display("FAIL reset_clocked: cmd_rdy=%b x_rdy=%b fwd=%b idx=%0d de=%h",
               cmd_rdy, x_rdy, fwd, idx, de);
    end
    wipe();
    rst = 1;
    repeat (8) @(posedge clk); #1;
    n_chk++;
    if (stq.size() + clrq.size() + doneq.size() + resq.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: strobes=%0d clr=%0d done=%0d res=%0d want 0",
               stq.size(), clrq.size(), doneq.size(), resq.size());
    end
    x_vld = 0;
  endtask

  task automatic test_forward();
    int tres, a;
    wmem[0] = 1; wmem[1] = 1; wmem[2] = 1;
    xs[0] = 2; xs[1] = 3; xs[2] = 4;
    run(0, 3, 16'h0, 0, 0, tres);
    a = t0();
    n_chk++;
    if (clrq.size() != 1 || (clrq.size() == 1 && clrq[0] != a + 1)) begin
      n_fail++;
      $display("FAIL fwd_clr: count=%0d want 1 at cycle %0d", clrq.size(), a + 1);
    end
    n_chk++;
    if (stq.size() != 3) begin
      n_fail++;
      $display("FAIL fwd_strobe_count: got %0d want 3", stq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (stq[k].c != a + 2 + k || stq[k].i != k || stq[k].b !== 1'b0
            || stq[k].d !== xs[k]) begin
          n_fail++;
          $display("FAIL fwd_strobe%0d: cyc=%0d idx=%0d dx=%h want cyc=%0d idx=%0d dx=%h",
                   k, stq[k].c - a, stq[k].i, stq[k].d, 2 + k, k, xs[k]);
        end
      end
    end
    n_chk++;
    if (tres != a + 3 + MAC_LAT + 2) begin
      n_fail++;
      $display("FAIL fwd_res_cycle: got %0d want %0d", tres - a, 3 + MAC_LAT + 2);
    end
    n_chk++;
    if (ry0 !== 16'd9 || resq.size() != 1) begin
      n_fail++;
      $display("FAIL fwd_res_y: got %0d (vld %0d cyc) want 9 (1 cyc)",
               ry0, resq.size());
    end
  endtask

  task automatic test_backward();
    int tres, a;
    xs[0] = DW'($urandom); xs[1] = DW'($urandom);
    run(1, 2, 16'd5, 0, 0, tres);
    a = t0();
    n_chk++;
    if (stq.size() != 2) begin
      n_fail++;
      $display("FAIL bwd_strobe_count: got %0d want 2", stq.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (stq[k].c != a + 2 + k || stq[k].i != k || stq[k].b !== 1'b1
            || stq[k].e !== 16'd5 || stq[k].d !== xs[k]) begin
          n_fail++;
          $display("FAIL bwd_strobe%0d: cyc=%0d idx=%0d bwd=%b de=%0d want cyc=%0d idx=%0d bwd=1 de=5",
                   k, stq[k].c - a, stq[k].i, stq[k].b, stq[k].e, 2 + k, k);
        end
      end
    end
    n_chk++;
    if (doneq.size() != 1 || (doneq.size() == 1 && doneq[0] != a + 2 + MAC_LAT + 2)) begin
      n_fail++;
      $display("FAIL bwd_done: count=%0d first=%0d want 1 at %0d",
               doneq.size(), doneq.size() ? doneq[0] - a : -1, 2 + MAC_LAT + 2);
    end
    n_chk++;
    if (clrq.size() != 0 || resq.size() != 0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bwd_side: clr=%0d res_vld=%0d cmd_rdy=%b want 0 0 1",
               clrq.size(), resq.size(), cmd_rdy);
    end
  endtask

  task automatic test_stall();
    int tres;
    logic [DW-1:0] ey;
    for (int k = 0; k < 4; k++) begin
      wmem[k] = DW'($urandom_range(1, 50));
      xs[k] = DW'($urandom_range(1, 50));
    end
    ey = model_y(4);
    run(0, 4, 16'h0, 1, 3, tres);
    n_chk++;
    if (stq.size() != 4 || xaq.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: strobes=%0d accepts=%0d want 4", stq.size(), xaq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (stq[k].i != k || stq[k].c != xaq[k] + 1 || stq[k].d !== xs[k]) begin
          n_fail++;
          $display("FAIL stall_strobe%0d: idx=%0d dx=%h lag=%0d want idx=%0d dx=%h lag=1",
                   k, stq[k].i, stq[k].d, stq[k].c - xaq[k], k, xs[k]);
        end
      end
      n_chk++;
      if (tres != xaq[3] + MAC_LAT + 2) begin
        n_fail++;
        $display("FAIL stall_res_cycle: got %0d want %0d after last accept",
                 tres - xaq[3], MAC_LAT + 2);
      end
    end
    n_chk++;
    if (ry0 !== ey || ryflip || resq.size() != 4) begin
      n_fail++;
      $display("FAIL stall_res: y=%h flip=%0b vld_cycles=%0d want y=%h flip=0 cycles=4",
               ry0, ryflip, resq.size(), ey);
    end
    n_chk++;
    if (cmd_rdy !== 1'b1 || res_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_after: cmd_rdy=%b res_vld=%b want 1 0", cmd_rdy, res_vld);
    end
  endtask

  task automatic test_len_zero();
    int tres, a;
    run(0, 0, 16'h0, 0, 0, tres);
    a = t0();
    n_chk++;
    if (stq.size() != 0 || ry0 !== '0 || tres != a + MAC_LAT + 2
        || clrq.size() != 1) begin
      n_fail++;
      $display("FAIL len0_fwd: strobes=%0d y=%h res_cyc=%0d clr=%0d want 0 0 %0d 1",
               stq.size(), ry0, tres - a, clrq.size(), MAC_LAT + 2);
    end
    run(1, 0, 16'h7, 0, 0, tres);
    a = t0();
    n_chk++;
    if (stq.size() != 0 || doneq.size() != 1 || tres != a + MAC_LAT + 2
        || clrq.size() != 0) begin
      n_fail++;
      $display("FAIL len0_bwd: strobes=%0d done=%0d done_cyc=%0d clr=%0d want 0 1 %0d 0",
               stq.size(), doneq.size(), tres - a, clrq.size(), MAC_LAT + 2);
    end
  endtask

  task automatic test_clamp();
    int tres, a, bad;
    logic [DW-1:0] ey;
    for (int k = 0; k < 128; k++) xs[k] = DW'($urandom);
    for (int k = 0; k < N_MAX; k++) wmem[k] = DW'($urandom);
    ey = model_y(127);
    run(0, 127, 16'h0, 0, 0, tres);
    a = t0();
    n_chk++;
    if (stq.size() != N_MAX) begin
      n_fail++;
      $display("FAIL clamp_count: got %0d want %0d", stq.size(), N_MAX);
    end else begin
      bad = -1;
      for (int k = 0; k < N_MAX; k++)
        if (stq[k].i != k || stq[k].d !== xs[k]) bad = k;
      n_chk++;
      if (bad >= 0 || stq[N_MAX-1].i != N_MAX - 1) begin
        n_fail++;
        $display("FAIL clamp_idx: bad element %0d last idx=%0d want %0d",
                 bad, stq[N_MAX-1].i, N_MAX - 1);
      end
    end
    n_chk++;
    if (ry0 !== ey || tres != a + N_MAX + MAC_LAT + 2) begin
      n_fail++;
      $display("FAIL clamp_res: y=%h cyc=%0d want y=%h cyc=%0d",
               ry0, tres - a, ey, N_MAX + MAC_LAT + 2);
    end
  endtask

  task automatic test_cmd_ignored();
    int n, per;
    per = 3 + MAC_LAT + 2;
    wipe();
    cmd_bwd = 1; cmd_len = 7'd3; cmd_e = 16'h0042; cmd_vld = 1;
    x_vld = 1; x = 16'h0011;
    n = 0;
    while (accq.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    cmd_vld = 0;
    n = 0;
    while (doneq.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    x_vld = 0;
    n_chk++;
    if (accq.size() != 2 || doneq.size() != 2) begin
      n_fail++;
      $display("FAIL busy_counts: accepts=%0d dones=%0d want 2 2",
               accq.size(), doneq.size());
    end else begin
      n_chk++;
      if (accq[1] - accq[0] != per || doneq[0] != accq[1]
          || doneq[1] != accq[1] + per) begin
        n_fail++;
        $display("FAIL busy_timing: gap=%0d done0-acc1=%0d want gap=%0d 0",
                 accq[1] - accq[0], doneq[0] - accq[1], per);
      end
    end
    n_chk++;
    if (stq.size() != 6 || clrq.size() != 0) begin
      n_fail++;
      $display("FAIL busy_strobes: got %0d clr=%0d want 6 0", stq.size(), clrq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_chk++;
        if (stq[k].i != k % 3 || stq[k].d !== 16'h0011 || stq[k].e !== 16'h0042) begin
          n_fail++;
          $display("FAIL busy_strobe%0d: idx=%0d dx=%h de=%h want idx=%0d dx=0011 de=0042",
                   k, stq[k].i, stq[k].d, stq[k].e, k % 3);
        end
      end
    end
  endtask

  task automatic test_random();
    int tres, a, elen, len, stall, rdly, r, tend;
    logic b;
    logic [DW-1:0] e, ey;
    for (int it = 0; it < 24; it++) begin
      b = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(90, 127) : $urandom_range(1, 12);
      stall = $urandom_range(0, 2);
      rdly = $urandom_range(0, 3);
      e = DW'($urandom);
      for (int k = 0; k < 128; k++) xs[k] = DW'($urandom);
      for (int k = 0; k < N_MAX; k++) wmem[k] = DW'($urandom);
      elen = clampl(len);
      ey = model_y(len);
      run(b, len, e, stall, rdly, tres);
      a = t0();
      n_chk++;
      if (stq.size() != elen || xaq.size() != elen) begin
        n_fail++;
        $display("FAIL rnd%0d_count: strobes=%0d accepts=%0d want %0d",
                 it, stq.size(), xaq.size(), elen);
        continue;
      end
      for (int k = 0; k < elen; k++) begin
        n_chk++;
        if (stq[k].i != k || stq[k].d !== xs[k] || stq[k].b !== b
            || stq[k].e !== e || stq[k].c != xaq[k] + 1
            || (stall == 0 && xaq[k] != a + 1 + k)) begin
          n_fail++;
          $display("FAIL rnd%0d_strobe%0d: idx=%0d dx=%h bwd=%b de=%h want idx=%0d dx=%h bwd=%b de=%h",
                   it, k, stq[k].i, stq[k].d, stq[k].b, stq[k].e, k, xs[k], b, e);
        end
      end
      tend = (elen == 0 ? a : xaq[elen-1]) + MAC_LAT + 2;
      n_chk++;
      if (tres != tend) begin
        n_fail++;
        $display("FAIL rnd%0d_end_cycle: got %0d want %0d", it, tres - a, tend - a);
      end
      n_chk++;
      if (!b && (ry0 !== ey || ryflip || resq.size() != rdly + 1
                 || clrq.size() != 1 || doneq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_fwd_res: y=%h vld=%0d clr=%0d done=%0d want y=%h vld=%0d clr=1 done=0",
                 it, ry0, resq.size(), clrq.size(), doneq.size(), ey, rdly + 1);
      end else if (b && (doneq.size() != 1 || resq.size() != 0 || clrq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd%0d_bwd_done: done=%0d res=%0d clr=%0d want 1 0 0",
                 it, doneq.size(), resq.size(), clrq.size());
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_stall();
    test_len_zero();
    test_clamp();
    test_cmd_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Sequencer for the single-neuron MAC datapath (`core`). It accepts forward or backward commands and streams input samples into the datapath under a valid/ready handshake. For each sample it drives the weight index and one forward or backward MAC strobe, waits out the datapath latency, then returns the forward result `y` or signals backward-pass completion.

## Interface
- `N_MAX`, 100, weight-memory depth; maximum elements per command
- `DW`, 16, data width of x, e, y
- `IW`, 7, index width (ceil(log2(N_MAX)))
- `MAC_LAT`, 1, cycles from a strobe cycle until its effect is visible on `y_in` (≥1)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_vld`  in  1  command valid
- `cmd_rdy`  out  1  command ready; high only in IDLE
- `cmd_bwd`  in  1  0 = forward pass, 1 = backward pass
- `cmd_len`  in  IW  element count
- `cmd_e`  in  DW  error term; latched on command acceptance, used for backward pass
- `x_vld`  in  1  sample valid
- `x_rdy`  out  1  sample ready
- `x`  in  DW  sample
- `idx`  out  IW  weight index to the datapath
- `fwd`  out  1  forward MAC strobe
- `bwd`  out  1  backward (weight-update) strobe
- `clr`  out  1  accumulator clear pulse
- `dx`  out  DW  registered sample to the datapath
- `de`  out  DW  latched error to the datapath
- `y_in`  in  DW  datapath accumulator
- `res_vld`  out  1  forward result valid
- `res_rdy`  in  1  result accepted
- `res_y`  out  DW  captured forward result
- `done`  out  1  one-cycle pulse marking backward-pass completion

## Operation
- States:
  - IDLE: `cmd_rdy`=1; all strobes low.
  - STREAM: `x_rdy`=1.
  - DRAIN: counts MAC_LAT+1 cycles.
  - RESULT: `res_vld`=1.
- IDLE→STREAM on `cmd_vld&cmd_rdy`.
  - Latch `cmd_bwd`, `cmd_e`→`de`, and len = min(`cmd_len`, N_MAX).
  - Reset the element counter to 0.
  - A forward command asserts `clr` for exactly the first STREAM cycle. A backward command never asserts `clr`.
- `cmd_len`=0: go directly to DRAIN without any strobe.
  - Forward then returns `res_y`=`y_in`, i.e. the cleared accumulator, 0.
  - Backward pulses `done`.
- STREAM, on each `x_vld&x_rdy`, the next cycle has:
  - `dx`=x and `idx`=count.
  - `fwd`=1 or `bwd`=1 according to mode, for exactly one cycle.
  - count increments.
- On acceptance of element len-1, the next state is DRAIN and `x_rdy` drops in that cycle.
- No `x_vld` in STREAM: hold; strobes stay low; no timeout.
- DRAIN, at the end of its last cycle:
  - Forward: `res_y`←`y_in`, go to RESULT.
  - Backward: `done`=1 in the following cycle, go to IDLE.
- RESULT: hold `res_vld` and `res_y` stable until `res_rdy`. On `res_vld&res_rdy`, go to IDLE next cycle.
- Outputs change only while the relevant strobe is high:
  - `idx` and `dx` hold their last values when `fwd`/`bwd` are low.
  - `de` holds until the next command acceptance.
- Width rules:
  - `idx` never exceeds N_MAX-1.
  - Count saturates at len; there is no wrap.
  - The controller does no arithmetic on data.
- Commands presented while not in IDLE are ignored, because `cmd_rdy`=0.
- `x_vld` outside STREAM is ignored, because `x_rdy`=0.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; `cmd_rdy`=1; `x_rdy`=`fwd`=`bwd`=`clr`=`res_vld`=`done`=0; `idx`=0; `dx`=`de`=`res_y`=0.
- Reset mid-operation aborts immediately. No `done` or `res_vld` is produced for the aborted command.
- Strobes, `clr`, `idx`, `dx`, `de`, `res_*` and `done` are registered. `cmd_rdy` and `x_rdy` are decoded directly from the state register.
- Cycle numbering: acceptance edge ends cycle 0; cycle 1 is the first STREAM cycle.
- Unstalled streaming (`x_vld` held high):
  - Samples are accepted in cycles 1..len.
  - Strobes occur in cycles 2..len+1.
  - `res_vld`, or the `done` pulse, first appears in cycle len+MAC_LAT+2.
- Throughput is one element per cycle. The next command can be accepted in the cycle after the `res_vld&res_rdy` handshake, or in the cycle of `done`.
- With `res_rdy` already high, `res_vld` is high for exactly one cycle.

## Test plan
- Reset check: assert `rst`=0 mid-stream, pulse `clk` → all outputs at their reset values and `cmd_rdy`=1. Release reset → no spurious strobes.
- Forward pass, len=3, MAC_LAT=1, `x_vld` held high, x=2,3,4, model datapath with y=Σw·x and w=1,1,1:
  - `clr` high in cycle 1.
  - `fwd` high in cycles 2–4 with `idx`=0,1,2.
  - `res_vld` in cycle 6 with `res_y`=9.
- Backward pass, len=2, `cmd_e`=5:
  - `bwd` high in cycles 2–3 with `idx`=0,1 and `de`=5.
  - `done` high in cycle 5 only; `clr` never asserted.
- Stalls, forward len=4: `x_vld` toggles 1,0,1,0… and `res_rdy` is held low for 3 cycles → exactly 4 `fwd` strobes, `idx` 0–3 in order; `res_y` stable while `res_vld` is held; IDLE the cycle after the handshake.
- Boundaries:
  - `cmd_len`=0 forward → no strobes, `res_y`=0.
  - `cmd_len`=127 → clamped to 100 strobes, last `idx`=99.
- Command presented during STREAM → ignored. The next command is accepted only after return to IDLE.
